// File: rtl/gauss_sobel_pkg.sv
// gauss_sobel_pkg: shared widths, kernel constants and helpers for the Gauss/Sobel engine
package gauss_sobel_pkg;
    localparam int PIX_W       = 8;
    localparam int SUM_W       = 12;
    localparam int GRAD_W      = 11;
    localparam int MAG_W       = 11;
    localparam int GAUSS_SHIFT = 4;
    localparam int SOBEL_SHIFT = 2;
    localparam logic [2:0] GAUSS_K [9] = '{3'd1, 3'd2, 3'd1, 3'd2, 3'd4, 3'd2, 3'd1, 3'd2, 3'd1};

    function automatic logic [GRAD_W-1:0] zx(input logic [PIX_W-1:0] p);
        return GRAD_W'(p);
    endfunction
endpackage

// File: rtl/conv_settle_ctrl.sv
// conv_settle_ctrl: counts cycles of continuous enable and raises done after SETTLE edges
module conv_settle_ctrl
    import gauss_sobel_pkg::*;
#(
    parameter int SETTLE = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic i_en,
    output logic o_done
);
    logic [5:0] r_cnt;
    logic       r_done;

    // done is registered alongside the count so it rises on the SETTLE-th enabled edge
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else begin
            r_cnt  <= !i_en ? 6'd0 : (r_cnt == 6'(SETTLE)) ? r_cnt : r_cnt + 6'd1;
            r_done <= i_en && (r_cnt >= 6'(SETTLE - 1));
        end
    end

    assign o_done = r_done;
endmodule

// File: rtl/gauss_sobel_engine.sv
// gauss_sobel_engine: independent 3x3 Gauss smoothing and Sobel gradient channels,
// each a 3-stage registered datapath gated by its own settle/done handshake.
module gauss_sobel_engine
    import gauss_sobel_pkg::*;
#(
    parameter int SETTLE = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          g_en_i,
    input  logic [PIX_W-1:0]              g_data_i_0,
    input  logic [PIX_W-1:0]              g_data_i_1,
    input  logic [PIX_W-1:0]              g_data_i_2,
    input  logic [PIX_W-1:0]              g_data_i_3,
    input  logic [PIX_W-1:0]              g_data_i_4,
    input  logic [PIX_W-1:0]              g_data_i_5,
    input  logic [PIX_W-1:0]              g_data_i_6,
    input  logic [PIX_W-1:0]              g_data_i_7,
    input  logic [PIX_W-1:0]              g_data_i_8,
    output logic [PIX_W-1:0]              g_data_o,
    output logic                          g_sonuc_done,
    input  logic                          s_en_i,
    input  logic [PIX_W-1:0]              s_data_i_0,
    input  logic [PIX_W-1:0]              s_data_i_1,
    input  logic [PIX_W-1:0]              s_data_i_2,
    input  logic [PIX_W-1:0]              s_data_i_3,
    input  logic [PIX_W-1:0]              s_data_i_4,
    input  logic [PIX_W-1:0]              s_data_i_5,
    input  logic [PIX_W-1:0]              s_data_i_6,
    input  logic [PIX_W-1:0]              s_data_i_7,
    input  logic [PIX_W-1:0]              s_data_i_8,
    output logic [MAG_W-SOBEL_SHIFT-1:0]  s_data_o,
    output logic                          s_sonuc_done
);
    logic [PIX_W-1:0]             w_g_in [9];
    logic [PIX_W-1:0]             w_s_in [9];
    logic [PIX_W-1:0]             r_g [9];
    logic [PIX_W-1:0]             r_s [9];
    logic [SUM_W-1:0]             w_gsum;
    logic [SUM_W-1:0]             r_gsum;
    logic [GRAD_W-1:0]            w_gx;
    logic [GRAD_W-1:0]            w_gy;
    logic [GRAD_W-1:0]            r_gx;
    logic [GRAD_W-1:0]            r_gy;
    logic [GRAD_W-1:0]            w_ax;
    logic [GRAD_W-1:0]            w_ay;
    logic [MAG_W-1:0]             w_mag;
    logic [PIX_W-1:0]             r_gout;
    logic [MAG_W-SOBEL_SHIFT-1:0] r_sout;

    assign w_g_in = '{g_data_i_0, g_data_i_1, g_data_i_2, g_data_i_3, g_data_i_4,
                      g_data_i_5, g_data_i_6, g_data_i_7, g_data_i_8};
    assign w_s_in = '{s_data_i_0, s_data_i_1, s_data_i_2, s_data_i_3, s_data_i_4,
                      s_data_i_5, s_data_i_6, s_data_i_7, s_data_i_8};

    always_comb begin
        w_gsum = '0;
        for (int k = 0; k < 9; k++) w_gsum = w_gsum + SUM_W'(r_g[k]) * SUM_W'(GAUSS_K[k]);
    end

    // gradients wrap in 11-bit two's complement; |x| of -1020 still fits unsigned
    assign w_gx  = (zx(r_s[2]) + (zx(r_s[5]) << 1) + zx(r_s[8]))
                 - (zx(r_s[0]) + (zx(r_s[3]) << 1) + zx(r_s[6]));
    assign w_gy  = (zx(r_s[6]) + (zx(r_s[7]) << 1) + zx(r_s[8]))
                 - (zx(r_s[0]) + (zx(r_s[1]) << 1) + zx(r_s[2]));
    assign w_ax  = r_gx[GRAD_W-1] ? -r_gx : r_gx;
    assign w_ay  = r_gy[GRAD_W-1] ? -r_gy : r_gy;
    assign w_mag = MAG_W'(w_ax) + MAG_W'(w_ay);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < 9; k++) begin
                r_g[k] <= '0;
                r_s[k] <= '0;
            end
            r_gsum <= '0;
            r_gx   <= '0;
            r_gy   <= '0;
            r_gout <= '0;
            r_sout <= '0;
        end else begin
            r_g    <= w_g_in;
            r_s    <= w_s_in;
            r_gsum <= w_gsum;
            r_gx   <= w_gx;
            r_gy   <= w_gy;
            r_gout <= r_gsum[SUM_W-1:GAUSS_SHIFT];
            r_sout <= w_mag[MAG_W-1:SOBEL_SHIFT];
        end
    end

    assign g_data_o = r_gout;
    assign s_data_o = r_sout;

    conv_settle_ctrl #(.SETTLE(SETTLE)) u_g_ctrl (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .i_en  (g_en_i),
        .o_done(g_sonuc_done)
    );

    conv_settle_ctrl #(.SETTLE(SETTLE)) u_s_ctrl (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .i_en  (s_en_i),
        .o_done(s_sonuc_done)
    );
endmodule

// File: tb/tb_gauss_sobel_engine.sv
// tb_gauss_sobel_engine: directed windows with a per-channel expected-result queue
// drained by a monitor on each rising done.
module tb_gauss_sobel_engine;
    localparam int SETTLE = 8;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       g_en_i = 1'b0;
    logic       s_en_i = 1'b0;
    logic [7:0] gw [9];
    logic [7:0] sw [9];
    logic [7:0] g_data_o;
    logic [8:0] s_data_o;
    logic       g_sonuc_done;
    logic       s_sonuc_done;
    logic       g_prev = 1'b0;
    logic       s_prev = 1'b0;
    int         g_exp [$];
    int         s_exp [$];
    int         checks = 0;
    int         errors = 0;

    always #5 clk_i = ~clk_i;

    gauss_sobel_engine #(.SETTLE(SETTLE)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .g_en_i      (g_en_i),
        .g_data_i_0  (gw[0]), .g_data_i_1(gw[1]), .g_data_i_2(gw[2]),
        .g_data_i_3  (gw[3]), .g_data_i_4(gw[4]), .g_data_i_5(gw[5]),
        .g_data_i_6  (gw[6]), .g_data_i_7(gw[7]), .g_data_i_8(gw[8]),
        .g_data_o    (g_data_o),
        .g_sonuc_done(g_sonuc_done),
        .s_en_i      (s_en_i),
        .s_data_i_0  (sw[0]), .s_data_i_1(sw[1]), .s_data_i_2(sw[2]),
        .s_data_i_3  (sw[3]), .s_data_i_4(sw[4]), .s_data_i_5(sw[5]),
        .s_data_i_6  (sw[6]), .s_data_i_7(sw[7]), .s_data_i_8(sw[8]),
        .s_data_o    (s_data_o),
        .s_sonuc_done(s_sonuc_done)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // monitor: each new done pops that channel's expected result
    always @(negedge clk_i) begin
        if (g_sonuc_done && !g_prev) begin
            if (g_exp.size() == 0) chk("g_unexpected_done", 1, 0);
            else chk("g_data", int'(g_data_o), g_exp.pop_front());
        end
        if (s_sonuc_done && !s_prev) begin
            if (s_exp.size() == 0) chk("s_unexpected_done", 1, 0);
            else chk("s_data", int'(s_data_o), s_exp.pop_front());
        end
        g_prev <= g_sonuc_done;
        s_prev <= s_sonuc_done;
    end

    task automatic start(input bit eg, input bit es, input int ge, input int se);
        if (eg) g_exp.push_back(ge);
        if (es) s_exp.push_back(se);
        g_en_i = eg;
        s_en_i = es;
    endtask

    task automatic wait_done(input bit eg, input bit es);
        int lg = 0;
        int ls = 0;
        for (int n = 1; n <= 3 * SETTLE && ((eg && lg == 0) || (es && ls == 0)); n++) begin
            @(posedge clk_i);
            #1;
            if (eg && lg == 0 && g_sonuc_done) lg = n;
            if (es && ls == 0 && s_sonuc_done) ls = n;
        end
        if (eg) chk("g_latency", lg, SETTLE);
        if (es) chk("s_latency", ls, SETTLE);
    endtask

    task automatic stop(input bit eg, input bit es);
        @(negedge clk_i);
        g_en_i = 1'b0;
        s_en_i = 1'b0;
        @(posedge clk_i);
        #1;
        if (eg) chk("g_done_fall", int'(g_sonuc_done), 0);
        if (es) chk("s_done_fall", int'(s_sonuc_done), 0);
    endtask

    task automatic op(input bit eg, input bit es, input int ge, input int se);
        start(eg, es, ge, se);
        wait_done(eg, es);
        stop(eg, es);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        gw = '{default: 8'd0};
        sw = '{default: 8'd0};
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_g_data", int'(g_data_o), 0);
        chk("rst_s_data", int'(s_data_o), 0);
        chk("rst_g_done", int'(g_sonuc_done), 0);
        chk("rst_s_done", int'(s_sonuc_done), 0);
        rst_i = 1'b0;

        gw = '{default: 8'd100};
        sw = '{default: 8'd100};
        op(1, 1, 100, 0);

        gw = '{0, 0, 0, 0, 255, 0, 0, 0, 0};
        op(1, 0, 63, 0);
        gw = '{default: 8'd255};
        op(1, 0, 255, 0);

        sw = '{0, 0, 255, 0, 0, 255, 0, 0, 255};
        op(0, 1, 0, 255);
        sw = '{0, 0, 0, 0, 0, 0, 0, 0, 255};
        op(0, 1, 0, 127);
        sw = '{0, 0, 255, 0, 0, 255, 255, 255, 255};
        op(0, 1, 0, 382);

        // abort mid-settle: done must never rise for this window
        gw = '{default: 8'd50};
        seen = 0;
        g_en_i = 1'b1;
        repeat (5) begin
            @(posedge clk_i);
            #1;
            if (g_sonuc_done) seen = 1;
        end
        g_en_i = 1'b0;
        repeat (SETTLE) begin
            @(posedge clk_i);
            #1;
            if (g_sonuc_done) seen = 1;
        end
        chk("abort_done", seen, 0);
        op(1, 0, 50, 0);

        gw = '{10, 20, 30, 40, 50, 60, 70, 80, 90};
        sw = '{10, 20, 30, 40, 50, 60, 70, 80, 90};
        op(1, 1, 50, 80);

        // reset with both dones high, then re-settle with enables still held
        gw = '{default: 8'd100};
        sw = '{0, 0, 255, 0, 0, 255, 0, 0, 255};
        start(1, 1, 100, 255);
        wait_done(1, 1);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk("mid_rst_g_data", int'(g_data_o), 0);
        chk("mid_rst_s_data", int'(s_data_o), 0);
        chk("mid_rst_g_done", int'(g_sonuc_done), 0);
        chk("mid_rst_s_done", int'(s_sonuc_done), 0);
        rst_i = 1'b0;
        g_exp.push_back(100);
        s_exp.push_back(255);
        wait_done(1, 1);
        stop(1, 1);

        repeat (2) @(posedge clk_i);
        chk("g_queue_left", g_exp.size(), 0);
        chk("s_queue_left", s_exp.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/gauss_sobel_engine.md
Name: gauss_sobel_engine

Overview:
- Dual 3x3 convolution engine for the image edge-detection pipeline.
- Gauss channel smooths a 3x3 window of 8-bit pixels. Sobel channel computes gradient magnitude on a 3x3 window of smoothed pixels.
- Channels are independent, share clk_i/rst_i, and each has its own enable/done handshake.
- The surrounding controller fetches windows from frame RAM, holds them stable, and waits for done before capturing the result.

Parameters:
- SETTLE, 8, cycles en must stay high before done asserts; 4..63 allowed.
- PIX_W, 8, input pixel width.

Ports:
- clk_i  input  1  system clock, rising edge.
- rst_i  input  1  synchronous, active-high reset.
- g_en_i  input  1  Gauss enable; window valid while high.
- g_data_i_0..g_data_i_8  input  8 each  Gauss window, row-major (0=top-left, 4=centre, 8=bottom-right).
- g_data_o  output  8  smoothed pixel.
- g_sonuc_done  output  1  Gauss result valid.
- s_en_i  input  1  Sobel enable.
- s_data_i_0..s_data_i_8  input  8 each  Sobel window, row-major.
- s_data_o  output  9  gradient magnitude.
- s_sonuc_done  output  1  Sobel result valid.

Behaviour:
- Reset (rst_i=1 at a clock edge): all outputs 0, settle counters 0, pipeline registers 0. Reset dominates en.
- Inputs are sampled every cycle regardless of en. Arithmetic is fully registered with a 3-cycle input-to-output latency on both channels (SETTLE > 3 guarantees outputs reflect the held window).
- Gauss: sum = p0+2p1+p2+2p3+4p4+2p5+p6+2p7+p8 (12-bit unsigned, max 4080). g_data_o = sum>>4, truncated, max 255, no saturation needed.
- Sobel:
  - Gx = (p2+2p5+p8)-(p0+2p3+p6); Gy = (p6+2p7+p8)-(p0+2p1+p2). Both are 11-bit signed, range ±1020.
  - mag = |Gx|+|Gy| (11-bit unsigned, max 2040).
  - s_data_o = mag>>2, truncated, max 510.
- Handshake, per channel, with an independent counter:
  - en low: counter=0 and done=0 from the next edge.
  - en high: counter increments, saturating at SETTLE.
  - done=1 when the counter reaches SETTLE, i.e. on the SETTLE-th rising edge with en continuously high. It stays high while en stays high.
  - en dropping mid-settle aborts the operation: counter clears and done never asserts for that window.
  - A new en rise restarts the full SETTLE count.
  - data_o keeps tracking the pipeline while en is low (value is don't-care while done=0).
- Controller contract: the window must be held constant from en rise until done is observed. The controller deasserts en after capture, then done falls on the next edge.
- Both channels may be active simultaneously with no interaction.

Decomposition:
- Shared package gauss_sobel_pkg holds:
  - PIX_W, SUM_W=12, GRAD_W=11, MAG_W=11;
  - Gauss weight constants {1,2,1,2,4,2,1,2,1} and GAUSS_SHIFT=4;
  - SOBEL_SHIFT=2.
- One sub-module is natural: conv_settle_ctrl (en to settle-counter to done), instantiated once per channel.
- Kernel datapaths stay inline in the top.

Test Plan:
- All nine Gauss inputs 100, g_en_i high -> g_sonuc_done rises exactly 8 cycles after en rise, g_data_o=100. Sobel window all 100 -> s_data_o=0.
- Gauss centre 255, others 0 -> g_data_o=63. All 255 -> 255.
- Sobel vertical edge (left column 0, right column 255, others 0) -> s_data_o=255. Only p8=255 -> 127. p2,p5,p6,p7,p8=255, others 0 -> 382.
- Drop g_en_i after 5 cycles -> g_sonuc_done stays 0. Re-raise -> done 8 cycles later. Deassert after done -> done 0 next edge.
- Assert rst_i with both done high -> next edge all outputs 0. With en still high after reset release, done returns 8 cycles later.
- Both channels enabled together with different windows -> each result matches its own golden value; done timing independent and identical.
